multi_key_beeper: RTL and testbench

Parametrised successor to the single-key debounce-plus-beeper pair. It debounces NUM_KEYS raw active-low push-buttons and produces one-cycle press events. It drives a single buzzer output with a per-key square-wave tone, either as a fixed-length one-shot or held for as long as the key is pressed. It sits between the board push-buttons and the buzzer pin, and exports the debounced levels and events for other logic.

---
 rtl/multi_key_beeper.sv | 249 ++++++++++++++++++++++++
 tb/tb_multi_key_beeper.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_key_beeper.sv
// -----------------------------------------------------------------------------
// multi_key_beeper
//
// Debounces NUM_KEYS raw active-low push-buttons, produces one-cycle press
// events, and drives a single buzzer pin with a per-key square-wave tone.
// The tone is either a fixed-length one-shot started (or restarted) by a
// press, or is held for as long as any key is down.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   key        raw buttons, active-low, idle high, asynchronous to clk
//   mode       0 = one-shot tone per press, 1 = tone while a key is held
//   key_value  debounced key levels (1 = released)
//   key_flag   one-cycle pulse per accepted press (debounced 1->0 edge)
//   beep       square-wave buzzer drive
//   busy       high while the tone FSM is sounding
//
// Tone half-period for key k is TONE_HALF_BASE + k*TONE_STEP clock cycles.
// When several keys qualify at once, the lowest index selects the tone.
// -----------------------------------------------------------------------------
module multi_key_beeper #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int BEEP_CYCLES     = 5_000_000,
    parameter int TONE_HALF_BASE  = 12_500,
    parameter int TONE_STEP       = 2_500
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key,
    input  logic                mode,
    output logic [NUM_KEYS-1:0] key_value,
    output logic [NUM_KEYS-1:0] key_flag,
    output logic                beep,
    output logic                busy
);

    // Counter widths are sized to the largest value each counter ever holds.
    // The debounce counter peaks at DEBOUNCE_CYCLES-1, the duration counter
    // at BEEP_CYCLES and the tone counter at HALF_MAX-1.
    localparam int HALF_MAX = TONE_HALF_BASE + (NUM_KEYS - 1) * TONE_STEP;
    localparam int DB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int DUR_W    = $clog2(BEEP_CYCLES + 1);
    localparam int TONE_W   = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;
    localparam int SEL_W    = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DUR_W-1:0] DUR_LOAD = DUR_W'(BEEP_CYCLES);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_TONE = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Per-key synchronizer, debounce filter and press-edge detector
    // -------------------------------------------------------------------------
    logic [NUM_KEYS-1:0] w_key_value;
    logic [NUM_KEYS-1:0] w_key_flag;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_chan
            logic            r_sync1;
            logic            r_sync2;
            logic            r_level;
            logic            r_level_prev;
            logic            r_flag;
            logic [DB_W-1:0] r_db_cnt;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    // Synchronizer resets to the idle (released) level so a
                    // key held through reset must debounce again afterwards.
                    r_sync1      <= 1'b1;
                    r_sync2      <= 1'b1;
                    r_level      <= 1'b1;
                    r_level_prev <= 1'b1;
                    r_flag       <= 1'b0;
                    r_db_cnt     <= '0;
                end else begin
                    r_sync1 <= key[gi];
                    r_sync2 <= r_sync1;

                    // Count consecutive samples that disagree with the
                    // accepted level; any agreeing sample restarts the count.
                    if (r_sync2 != r_level) begin
                        if (r_db_cnt == DB_LAST) begin
                            r_level  <= r_sync2;
                            r_db_cnt <= '0;
                        end else begin
                            r_db_cnt <= r_db_cnt + DB_W'(1);
                        end
                    end else begin
                        r_db_cnt <= '0;
                    end

                    // Press event is taken from the registered level so it
                    // lands one cycle after the debounced level falls.
                    r_level_prev <= r_level;
                    r_flag       <= r_level_prev & ~r_level;
                end
            end

            assign w_key_value[gi] = r_level;
            assign w_key_flag[gi]  = r_flag;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Per-key half-period table (stored minus one: the terminal count)
    // -------------------------------------------------------------------------
    logic [TONE_W-1:0] w_half_m1_tbl [NUM_KEYS];

    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_half
            assign w_half_m1_tbl[gi] = TONE_W'(TONE_HALF_BASE + gi * TONE_STEP - 1);
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Tone FSM and generator state
    // -------------------------------------------------------------------------
    state_t             r_state;
    logic [SEL_W-1:0]   r_sel;
    logic [DUR_W-1:0]   r_dur;
    logic [TONE_W-1:0]  r_tone_cnt;
    logic               r_beep;
    logic               r_mode;

    state_t             w_state_next;
    logic [SEL_W-1:0]   w_sel_next;
    logic [DUR_W-1:0]   w_dur_next;
    logic [TONE_W-1:0]  w_tone_cnt_next;
    logic               w_beep_next;
    logic               w_restart;

    logic               w_flag_any;
    logic               w_held_any;
    logic [SEL_W-1:0]   w_flag_idx;
    logic [SEL_W-1:0]   w_held_idx;
    logic [TONE_W-1:0]  w_half_m1;

    // Lowest-index priority encoders and half-period lookup for the current
    // selection. Scanning from the top down leaves the lowest match last.
    always_comb begin
        w_flag_any = |w_key_flag;
        w_held_any = ~&w_key_value;
        w_flag_idx = '0;
        w_held_idx = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (w_key_flag[k]) begin
                w_flag_idx = SEL_W'(k);
            end
            if (!w_key_value[k]) begin
                w_held_idx = SEL_W'(k);
            end
        end

        w_half_m1 = w_half_m1_tbl[0];
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (r_sel == SEL_W'(k)) begin
                w_half_m1 = w_half_m1_tbl[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_sel      <= '0;
            r_dur      <= '0;
            r_tone_cnt <= '0;
            r_beep     <= 1'b0;
            r_mode     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_sel      <= w_sel_next;
            r_dur      <= w_dur_next;
            r_tone_cnt <= w_tone_cnt_next;
            r_beep     <= w_beep_next;
            r_mode     <= mode;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_sel_next      = r_sel;
        w_dur_next      = r_dur;
        w_tone_cnt_next = r_tone_cnt;
        w_beep_next     = r_beep;
        w_restart       = 1'b0;

        if (mode != r_mode) begin
            // Mode is changing on this edge: silence first; the new mode's
            // start condition is looked at from the following cycle.
            w_state_next = S_IDLE;
        end else if (!r_mode) begin
            // One-shot: any press (re)starts the tone, a press in the final
            // cycle still wins over expiry.
            if (w_flag_any) begin
                w_state_next = S_TONE;
                w_sel_next   = w_flag_idx;
                w_dur_next   = DUR_LOAD;
                w_restart    = 1'b1;
            end else if (r_state == S_TONE) begin
                if (r_dur <= DUR_W'(1)) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_dur_next = r_dur - DUR_W'(1);
                end
            end
        end else begin
            // Hold: follow the lowest held key every cycle.
            w_dur_next = '0;
            if (w_held_any) begin
                w_state_next = S_TONE;
                w_sel_next   = w_held_idx;
                if ((r_state == S_IDLE) || (w_held_idx != r_sel)) begin
                    w_restart = 1'b1;
                end
            end else begin
                w_state_next = S_IDLE;
            end
        end

        if (w_state_next == S_IDLE) begin
            w_dur_next      = '0;
            w_tone_cnt_next = '0;
            w_beep_next     = 1'b0;
        end else if (w_restart) begin
            // Every fresh tone begins on the high half of the wave.
            w_tone_cnt_next = '0;
            w_beep_next     = 1'b1;
        end else if (r_tone_cnt == w_half_m1) begin
            w_tone_cnt_next = '0;
            w_beep_next     = ~r_beep;
        end else begin
            w_tone_cnt_next = r_tone_cnt + TONE_W'(1);
        end
    end

    assign key_value = w_key_value;
    assign key_flag  = w_key_flag;
    assign beep      = r_beep;
    assign busy      = (r_state == S_TONE);

endmodule

// File: tb/tb_multi_key_beeper.sv
// -----------------------------------------------------------------------------
// tb_multi_key_beeper
//
// A reference model runs at every rising edge, derives the outputs expected
// for the coming cycle from the behavioural rules (stability window for the
// debounce, elapsed-time arithmetic for the tone) and queues them. A monitor
// pops one entry at every falling edge and compares it with the design.
// Directed checks cover latencies and the asynchronous reset.
// -----------------------------------------------------------------------------
module tb_multi_key_beeper;

    localparam int NK = 4;
    localparam int DB = 8;
    localparam int BC = 40;
    localparam int HB = 4;
    localparam int HS = 2;

    logic          clk  = 1'b0;
    logic          rst  = 1'b1;
    logic [NK-1:0] key  = 4'hF;
    logic          mode = 1'b0;
    logic [NK-1:0] key_value;
    logic [NK-1:0] key_flag;
    logic          beep;
    logic          busy;

    multi_key_beeper #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (DB),
        .BEEP_CYCLES     (BC),
        .TONE_HALF_BASE  (HB),
        .TONE_STEP       (HS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key       (key),
        .mode      (mode),
        .key_value (key_value),
        .key_flag  (key_flag),
        .beep      (beep),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NK-1:0] kv;
        logic [NK-1:0] fl;
        logic          bp;
        logic          bz;
    } obs_t;

    obs_t exp_q[$];

    int n_tests   = 0;
    int n_fail    = 0;
    int n         = 0;   // index of the cycle that began at the latest rising edge
    int flag1_cnt = 0;

    // Reference model state
    logic [NK-1:0] m_raw_q[$];   // raw samples still travelling through the synchronizer
    logic [NK-1:0] m_hist[$];    // most recent DB synchronized samples
    logic [NK-1:0] m_kv;
    logic [NK-1:0] m_flag;
    logic [NK-1:0] m_fell;
    bit            m_on;
    int            m_start;
    int            m_sel;
    logic          m_rmode;

    function automatic int lowest_set(input logic [NK-1:0] v);
        for (int i = 0; i < NK; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    function automatic int half_of(input int k);
        return HB + k * HS;
    endfunction

    task automatic model_step();
        logic [NK-1:0] synced;
        logic [NK-1:0] new_kv;
        bit            all_diff;
        obs_t          e;
        if (rst) begin
            m_raw_q = '{4'hF, 4'hF};
            m_hist.delete();
            m_kv    = 4'hF;
            m_flag  = 4'h0;
            m_fell  = 4'h0;
            m_on    = 1'b0;
            m_start = 0;
            m_sel   = 0;
            m_rmode = 1'b0;
        end else begin
            // Tone decision uses what was visible during the cycle just ended.
            if (mode != m_rmode) begin
                m_on = 1'b0;
            end else if (m_rmode == 1'b0) begin
                if (m_flag != 4'h0) begin
                    m_on    = 1'b1;
                    m_sel   = lowest_set(m_flag);
                    m_start = n;
                end else if (m_on && (n - m_start >= BC)) begin
                    m_on = 1'b0;
                end
            end else begin
                if (m_kv != 4'hF) begin
                    if (!m_on || lowest_set(~m_kv) != m_sel) begin
                        m_start = n;
                        m_sel   = lowest_set(~m_kv);
                    end
                    m_on = 1'b1;
                end else begin
                    m_on = 1'b0;
                end
            end
            m_rmode = mode;

            // A level is accepted once DB consecutive synchronized samples
            // all disagree with the current debounced level.
            synced = m_raw_q.pop_front();
            m_raw_q.push_back(key);
            m_hist.push_back(synced);
            if (m_hist.size() > DB) void'(m_hist.pop_front());
            new_kv = m_kv;
            for (int k = 0; k < NK; k++) begin
                if (m_hist.size() == DB) begin
                    all_diff = 1'b1;
                    foreach (m_hist[j]) begin
                        if (m_hist[j][k] == m_kv[k]) all_diff = 1'b0;
                    end
                    if (all_diff) new_kv[k] = ~m_kv[k];
                end
            end
            m_flag = m_fell;
            m_fell = m_kv & ~new_kv;
            m_kv   = new_kv;
        end
        e.kv = m_kv;
        e.fl = m_flag;
        e.bz = m_on;
        e.bp = m_on && (((n - m_start) / half_of(m_sel)) % 2 == 0);
        exp_q.push_back(e);
    endtask

    // Model: one step per rising edge
    initial begin
        forever begin
            @(posedge clk);
            n = n + 1;
            model_step();
        end
    end

    // Monitor: one comparison per falling edge
    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) continue;
            e = exp_q.pop_front();
            if (rst) e = '{kv: 4'hF, fl: 4'h0, bp: 1'b0, bz: 1'b0};
            a = '{kv: key_value, fl: key_flag, bp: beep, bz: busy};
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL cycle_match cycle %0d: got kv=%b flag=%b beep=%b busy=%b, want kv=%b flag=%b beep=%b busy=%b",
                         n, a.kv, a.fl, a.bp, a.bz, e.kv, e.fl, e.bp, e.bz);
            end else if (key_flag != 4'h0) begin
                $display("[TB] cycle %0d press flag=%b kv=%b", n, key_flag, key_value);
            end
            if (!rst && key_flag[1]) flag1_cnt++;
        end
    end

    task automatic check(input string name, input int got, input int want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Advance c rising edges, then settle 1 time unit before driving.
    task automatic tick(input int c);
        repeat (c) @(posedge clk);
        #1;
    endtask

    // Wait (bounded) at falling edges for a condition; at = cycle or -1.
    // which: 0 any key_flag, 1 busy high, 2 busy low, 3 all keys released
    task automatic wait_until(input int which, input int bound, output int at);
        bit hit;
        at = -1;
        for (int t = 0; t < bound; t++) begin
            @(negedge clk);
            case (which)
                0: hit = (key_flag != 4'h0);
                1: hit = (busy == 1'b1);
                2: hit = (busy == 1'b0);
                default: hit = (key_value == 4'hF);
            endcase
            if (hit) begin
                at = n;
                return;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e_edge;
        int at;
        int at2;
        int f;

        // Reset state
        tick(3);
        check("reset_key_value", key_value, 15);
        check("reset_key_flag", key_flag, 0);
        check("reset_beep", beep, 0);
        check("reset_busy", busy, 0);
        rst = 1'b0;
        tick(5);

        // Clean press, mode 0
        key    = 4'b1110;
        e_edge = n + 1;
        wait_until(0, 40, at);
        check("press_latency_cycle", at, e_edge + 10);
        check("press_flag_bits", key_flag, 1);
        wait_until(1, 5, at);
        check("tone_start_cycle", at, e_edge + 11);
        check("tone_start_beep", beep, 1);
        wait_until(2, 100, at2);
        check("oneshot_len", at2 - at, BC);
        tick(1);
        key = 4'hF;
        tick(20);

        // Bounced press: exactly one flag
        flag1_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            key[1] = i[0];
            tick(3);
        end
        key[1] = 1'b0;
        tick(25);
        check("bounce_press_flags", flag1_cnt, 1);

        // Bounced release: no flag, level returns high
        flag1_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            key[1] = ~i[0];
            tick(3);
        end
        key[1] = 1'b1;
        tick(25);
        check("bounce_release_flags", flag1_cnt, 0);
        check("bounce_release_level", key_value[1], 1);
        tick(30);

        // Simultaneous press, then retrigger by key 3
        key = 4'b0011;
        wait_until(0, 40, at);
        check("simul_flags", key_flag, 12);
        wait_until(1, 5, at);
        tick(4);
        key = 4'hF;
        tick(10);
        key = 4'b0111;
        wait_until(0, 40, f);
        check("retrigger_flag", key_flag, 8);
        wait_until(2, 100, at2);
        check("retrigger_len", at2 - f, BC + 1);
        tick(1);
        key = 4'hF;
        tick(20);

        // Hold mode
        mode = 1'b1;
        tick(3);
        key = 4'b0111;
        tick(20);
        key = 4'b0101;
        tick(30);
        key = 4'b0111;
        tick(30);
        key = 4'hF;
        wait_until(3, 30, at);
        check("hold_busy_at_release", busy, 1);
        @(negedge clk);
        check("hold_busy_after_release", busy, 0);
        check("hold_beep_after_release", beep, 0);
        tick(5);

        // Mode switch during a one-shot
        mode = 1'b0;
        tick(3);
        key = 4'b1110;
        wait_until(1, 40, at);
        tick(5);
        mode = 1'b1;
        @(negedge clk);
        check("mode_switch_busy_before", busy, 1);
        @(negedge clk);
        check("mode_switch_busy", busy, 0);
        check("mode_switch_beep", beep, 0);
        tick(1);
        key = 4'hF;
        tick(20);
        mode = 1'b0;
        tick(5);

        // Asynchronous reset mid-tone
        key = 4'b1011;
        wait_until(1, 40, at);
        tick(3);
        check("pre_reset_beep", beep, 1);
        #1 rst = 1'b1;
        #1;
        check("async_reset_beep", beep, 0);
        check("async_reset_busy", busy, 0);
        check("async_reset_flag", key_flag, 0);
        check("async_reset_key_value", key_value, 15);
        tick(2);
        rst = 1'b0;
        wait_until(0, 40, f);
        check("post_reset_flag", key_flag, 4);
        tick(50);
        key = 4'hF;
        tick(20);

        // Randomized keys and mode changes
        for (int i = 0; i < 40; i++) begin
            key = 4'($urandom);
            if ($urandom_range(0, 5) == 0) mode = ~mode;
            tick($urandom_range(1, 30));
        end
        key  = 4'hF;
        mode = 1'b0;
        tick(60);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
